// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues req/ack ROM fetches and buffers
// fetched words in a first-word-fall-through FIFO presented to the control stage.
module instruction_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_req,
  input  logic               rom_ack,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic [1:0]         ps,
  input  logic [63:0]        k
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [INSTR_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0]  mem_pc   [DEPTH];

  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
  logic [CNT_W-1:0]  count, count_next;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_next, rom_addr_next, target, k_low;
  logic              rom_req_next, discard, discard_next;
  logic              consume, pop, flush, ack, push, pending;
  logic              unused_k;

  assign k_low    = k[ADDR_W-1:0];
  assign unused_k = ^k;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? mem_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? mem_pc[rd_ptr]   : '0;

  assign consume = instr_valid && instr_ready;
  assign pop     = consume && (ps != 2'b00);
  assign flush   = consume && ps[1];
  assign target  = ps[0] ? k_low : instr_pc + (k_low << 2);
  assign ack     = rom_req && rom_ack;
  // A redirect drops the word arriving in the same cycle, and a word that was
  // requested before a redirect is dropped when it eventually returns.
  assign push    = ack && !discard && !flush;
  assign pending = rom_req && !rom_ack;

  always_comb begin
    count_next    = count;
    rd_ptr_next   = rd_ptr;
    wr_ptr_next   = wr_ptr;
    fetch_pc_next = fetch_pc;
    discard_next  = discard;
    rom_req_next  = 1'b0;
    rom_addr_next = rom_addr;

    if (flush) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr + PTR_W'(1);
      if (push && !pop)      count_next = count + CNT_W'(1);
      else if (pop && !push) count_next = count - CNT_W'(1);
    end

    if (flush)                fetch_pc_next = target;
    else if (ack && !discard) fetch_pc_next = fetch_pc + ADDR_W'(4);

    if (flush && pending) discard_next = 1'b1;
    else if (ack)         discard_next = 1'b0;

    // An outstanding request is frozen; otherwise launch only if the word it
    // returns is guaranteed a FIFO slot.
    if (pending) begin
      rom_req_next  = 1'b1;
      rom_addr_next = rom_addr;
    end else begin
      rom_req_next  = (count_next < CNT_W'(DEPTH));
      rom_addr_next = fetch_pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= RESET_PC;
      rom_addr <= RESET_PC;
      rom_req  <= 1'b0;
      discard  <= 1'b0;
    end else begin
      count    <= count_next;
      rd_ptr   <= rd_ptr_next;
      wr_ptr   <= wr_ptr_next;
      fetch_pc <= fetch_pc_next;
      rom_addr <= rom_addr_next;
      rom_req  <= rom_req_next;
      discard  <= discard_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= rom_data;
      mem_pc[wr_ptr]   <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural ROM (ROM[a] = a)
// whose ack latency is selectable per scenario.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rom_addr;
  logic        rom_req;
  logic        rom_ack = 1'b0;
  logic [31:0] rom_data = '0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [1:0]  ps = 2'b01;
  logic [63:0] k = '0;

  int total = 0;
  int bad = 0;
  int rom_wait = 0;
  int rom_wcnt = 0;

  instruction_fetch #(
    .ADDR_W  (32),
    .INSTR_W (32),
    .RESET_PC(32'h0),
    .DEPTH   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_addr   (rom_addr),
    .rom_req    (rom_req),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .ps         (ps),
    .k          (k)
  );

  always #5 clk = ~clk;

  // ROM: acks after rom_wait idle cycles of an asserted request
  initial forever begin
    @(negedge clk);
    if (!rst || !rom_req) begin
      rom_ack  = 1'b0;
      rom_wcnt = 0;
    end else begin
      if (rom_ack) rom_wcnt = 0;
      if (rom_wcnt >= rom_wait) begin
        rom_ack  = 1'b1;
        rom_data = rom_addr;
      end else begin
        rom_ack  = 1'b0;
        rom_data = 32'hDEAD_BEEF;
        rom_wcnt++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset(input int w, input logic rdy);
    @(negedge clk);
    rst = 1'b0; rom_wait = w; instr_ready = rdy; ps = 2'b01; k = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (rom_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", rom_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    total++; if (rom_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", rom_addr); end
    total++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h/%h want 0/0", instr, instr_pc); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (rom_req !== 1'b1 || rom_addr !== 32'h0) begin bad++; $display("FAIL first_req: got req=%b addr=%h want 1/0", rom_req, rom_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL first_valid_early: got %b want 0", instr_valid); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h0) begin bad++; $display("FAIL first_instr: got v=%b pc=%h i=%h want 1/0/0", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_stream;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr !== 32'(4 * i)) begin
        bad++; $display("FAIL stream_instr[%0d]: got v=%b pc=%h i=%h want 1/%h/%h", i, instr_valid, instr_pc, instr, 4 * i, 4 * i);
      end
      total++;
      if (rom_req !== 1'b1 || rom_addr !== 32'(4 * i + 4)) begin
        bad++; $display("FAIL stream_addr[%0d]: got req=%b addr=%h want 1/%h", i, rom_req, rom_addr, 4 * i + 4);
      end
    end
  endtask

  task automatic test_wait_states;
    logic exp_v;
    do_reset(3, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      exp_v = (c >= 5) && ((c - 1) % 4 == 0);
      total++;
      if (rom_req !== 1'b1 || rom_addr !== 32'(4 * ((c - 1) / 4))) begin
        bad++; $display("FAIL wait_addr[%0d]: got req=%b addr=%h want 1/%h", c, rom_req, rom_addr, 4 * ((c - 1) / 4));
      end
      total++;
      if (instr_valid !== exp_v) begin
        bad++; $display("FAIL wait_valid[%0d]: got %b want %b", c, instr_valid, exp_v);
      end else if (exp_v && (instr_pc !== 32'(4 * ((c - 1) / 4 - 1)) || instr !== instr_pc)) begin
        bad++; $display("FAIL wait_instr[%0d]: got pc=%h i=%h want %h", c, instr_pc, instr, 4 * ((c - 1) / 4 - 1));
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset(0, 1'b0);
    repeat (2) @(negedge clk);
    total++; if (rom_req !== 1'b1 || rom_addr !== 32'h4) begin bad++; $display("FAIL bp_second_req: got req=%b addr=%h want 1/4", rom_req, rom_addr); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (rom_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h0) begin
        bad++; $display("FAIL bp_full[%0d]: got req=%b v=%b pc=%h i=%h want 0/1/0/0", i, rom_req, instr_valid, instr_pc, instr);
      end
    end
    instr_ready = 1'b1;
    @(negedge clk);
    total++; if (rom_req !== 1'b1 || rom_addr !== 32'h8) begin bad++; $display("FAIL bp_resume_req: got req=%b addr=%h want 1/8", rom_req, rom_addr); end
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) @(negedge clk);
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr !== 32'(4 * i)) begin
        bad++; $display("FAIL bp_order[%0d]: got v=%b pc=%h i=%h want 1/%h", i, instr_valid, instr_pc, instr, 4 * i);
      end
    end
  endtask

  task automatic test_redirect;
    do_reset(0, 1'b0);
    repeat (3) @(negedge clk);
    total++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) begin bad++; $display("FAIL rd_pc0: got v=%b pc=%h want 1/0", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    @(negedge clk);
    total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL rd_pc4: got %h want 4", instr_pc); end
    @(negedge clk);
    total++; if (instr_pc !== 32'h8) begin bad++; $display("FAIL rd_pc8: got %h want 8", instr_pc); end
    // redirect fields are presented without a consume and must be ignored
    instr_ready = 1'b0; ps = 2'b11; k = 64'h999;
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || rom_req !== 1'b0) begin bad++; $display("FAIL rd_buffered: got v=%b pc=%h req=%b want 1/8/0", instr_valid, instr_pc, rom_req); end
    instr_ready = 1'b1; ps = 2'b10; k = 64'hFFFF_FFFF_0000_0003;
    @(negedge clk);
    ps = 2'b01; k = '0;
    total++; if (instr_valid !== 1'b0 || rom_req !== 1'b1 || rom_addr !== 32'h14) begin bad++; $display("FAIL rel_target: got v=%b req=%b addr=%h want 0/1/14", instr_valid, rom_req, rom_addr); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h14 || instr !== 32'h14) begin bad++; $display("FAIL rel_instr: got v=%b pc=%h i=%h want 1/14/14", instr_valid, instr_pc, instr); end
    instr_ready = 1'b0;
    @(negedge clk);
    total++; if (instr_pc !== 32'h14 || rom_req !== 1'b0) begin bad++; $display("FAIL abs_buffered: got pc=%h req=%b want 14/0", instr_pc, rom_req); end
    instr_ready = 1'b1; ps = 2'b11; k = 64'h1234_5678_0000_0040;
    @(negedge clk);
    ps = 2'b01; k = '0;
    total++; if (instr_valid !== 1'b0 || rom_addr !== 32'h40) begin bad++; $display("FAIL abs_target: got v=%b addr=%h want 0/40", instr_valid, rom_addr); end
    @(negedge clk);
    total++; if (instr_pc !== 32'h40 || instr !== 32'h40) begin bad++; $display("FAIL abs_instr: got pc=%h i=%h want 40/40", instr_pc, instr); end
    @(negedge clk);
    total++; if (instr_pc !== 32'h44) begin bad++; $display("FAIL abs_next: got %h want 44", instr_pc); end
  endtask

  task automatic test_redirect_outstanding;
    do_reset(3, 1'b1);
    repeat (17) @(negedge clk);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC || rom_addr !== 32'h10 || rom_req !== 1'b1) begin
      bad++; $display("FAIL out_pre: got v=%b pc=%h addr=%h req=%b want 1/c/10/1", instr_valid, instr_pc, rom_addr, rom_req);
    end
    ps = 2'b11; k = 64'h100;
    for (int i = 18; i <= 20; i++) begin
      @(negedge clk);
      ps = 2'b01; k = '0;
      total++;
      if (instr_valid !== 1'b0 || rom_addr !== 32'h10 || rom_req !== 1'b1) begin
        bad++; $display("FAIL out_hold[%0d]: got v=%b addr=%h req=%b want 0/10/1", i, instr_valid, rom_addr, rom_req);
      end
    end
    @(negedge clk);
    total++; if (rom_addr !== 32'h100 || rom_req !== 1'b1 || instr_valid !== 1'b0) begin bad++; $display("FAIL out_retarget: got addr=%h req=%b v=%b want 100/1/0", rom_addr, rom_req, instr_valid); end
    for (int i = 22; i <= 24; i++) begin
      @(negedge clk);
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL out_discard[%0d]: got v=%b pc=%h want v=0", i, instr_valid, instr_pc); end
    end
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== 32'h100) begin bad++; $display("FAIL out_instr: got v=%b pc=%h i=%h want 1/100/100", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_hold_and_reset;
    do_reset(0, 1'b1);
    repeat (3) @(negedge clk);
    total++; if (instr_pc !== 32'h4) begin bad++; $display("FAIL hold_first: got %h want 4", instr_pc); end
    ps = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4 || rom_req !== 1'b0) begin bad++; $display("FAIL hold_repeat[%0d]: got v=%b pc=%h req=%b want 1/4/0", i, instr_valid, instr_pc, rom_req); end
    end
    ps = 2'b01;
    @(negedge clk);
    total++; if (instr_pc !== 32'h8 || rom_req !== 1'b1 || rom_addr !== 32'hC) begin bad++; $display("FAIL hold_release: got pc=%h req=%b addr=%h want 8/1/c", instr_pc, rom_req, rom_addr); end
    #2 rst = 1'b0;
    #1;
    total++; if (rom_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL async_reset: got req=%b v=%b want 0/0", rom_req, instr_valid); end
    total++; if (rom_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0) begin bad++; $display("FAIL async_reset_vals: got addr=%h i=%h pc=%h want 0/0/0", rom_addr, instr, instr_pc); end
    @(negedge clk);
    total++; if (rom_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL reset_ack_ignored: got req=%b v=%b want 0/0", rom_req, instr_valid); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (rom_req !== 1'b1 || rom_addr !== 32'h0 || instr_valid !== 1'b0) begin bad++; $display("FAIL restart_req: got req=%b addr=%h v=%b want 1/0/0", rom_req, rom_addr, instr_valid); end
    @(negedge clk);
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin bad++; $display("FAIL restart_pc0: got v=%b pc=%h want 1/0", instr_valid, instr_pc); end
    @(negedge clk);
    total++; if (instr_pc !== 32'h4 || instr !== 32'h4) begin bad++; $display("FAIL restart_pc4: got pc=%h i=%h want 4/4", instr_pc, instr); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_wait_states;
    test_backpressure;
    test_redirect;
    test_redirect_outstanding;
    test_hold_and_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the processor: owns the program counter, drives the instruction ROM address (`rom_addr`) through a req/ack handshake, and buffers fetched words in a small FIFO. It presents instructions to the control/decode stage, which produces the control word. The control stage consumes an instruction together with its PC-select (`ps`) and constant (`k`) fields, and the fetch stage advances, holds or redirects the PC accordingly.

## Interface
- `ADDR_W`, 32, PC / ROM address width
- `INSTR_W`, 32, instruction width
- `RESET_PC`, 0, PC value loaded on reset
- `DEPTH`, 2, instruction FIFO entries (power of two, ≥2)

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous, active-low; one clock domain
- `rom_addr`  out  ADDR_W  fetch address; registered
- `rom_req`  out  1  fetch request; registered
- `rom_ack`  in  1  ROM completes the transfer in any cycle with `rom_req && rom_ack`
- `rom_data`  in  INSTR_W  instruction word; valid in the ack cycle
- `instr`  out  INSTR_W  FIFO head instruction
- `instr_pc`  out  ADDR_W  address of `instr`
- `instr_valid`  out  1  FIFO non-empty
- `instr_ready`  in  1  control stage accepts the head this cycle
- `ps`  in  2  PC select, sampled only on consume
- `k`  in  64  constant/offset, sampled only on consume; low ADDR_W bits are used

## Operation
- Consume = `instr_valid && instr_ready`. On consume, `ps` selects the action:
  - 00: hold. The head is not popped and is re-presented next cycle (multi-cycle ops).
  - 01: pop. Sequential flow continues.
  - 10: pop, flush the FIFO, and redirect to `instr_pc + (k[ADDR_W-1:0] << 2)`, mod 2^ADDR_W.
  - 11: pop, flush the FIFO, and redirect to `k[ADDR_W-1:0]`.
- Inputs `ps` and `k` are ignored when there is no consume.
- Internal `fetch_pc` is the next address to request. Each accepted ack pushes `{fetch_pc, rom_data}` and advances `fetch_pc` by 4, wrapping mod 2^ADDR_W.
- Handshake rules:
  - At most one request is outstanding.
  - Once `rom_req` is high, `rom_addr` and `rom_req` stay stable until ack.
  - Back-to-back requests are allowed: `rom_req` may stay high with the next address on the cycle after an ack.
- Request launch: `rom_req` is asserted (or kept high after an ack) at an edge only if the FIFO count after that edge, plus the new request, is ≤ DEPTH. Result: the FIFO never overflows and no ack is ever dropped for lack of space.
- Redirect with no outstanding request: `fetch_pc` ← target, and a request to the target is launched at the same edge.
- Redirect while a request is outstanding: `rom_addr` is not changed. A `discard` flag is set and the returning word is dropped (no push). The target is held in `fetch_pc` and requested on the cycle after the ack.
- Redirect coinciding with the ack cycle: that ack's data is dropped.
- Simultaneous pop and push on a non-flush cycle: count is unchanged.
- Flush wins over push in the same cycle.

## Timing
- Reset (`rst`=0, asynchronous) values:
  - `fetch_pc`=`RESET_PC`, `rom_addr`=`RESET_PC`
  - `rom_req`=0, `instr_valid`=0, FIFO empty, `discard`=0
  - `instr` and `instr_pc` read 0
- After reset release: `rom_req` rises at the first rising edge.
- Zero-wait ROM (ack in the request cycle): first `instr_valid` appears one cycle after the ack. Steady throughput is one instruction per cycle.
- FIFO output is first-word-fall-through: `instr`/`instr_pc` are valid whenever `instr_valid` is high, with no extra read cycle.
- Redirect latency, zero-wait ROM, no request outstanding: consume at cycle N → `rom_addr` = target in N+1 → target's `instr_valid` in N+2.
- Reset asserted mid-request: the request is abandoned immediately. Any ack arriving during reset is ignored.

## Test plan
- Reset release with a zero-wait ROM (`ROM[a]=a`), `instr_ready`=1, `ps`=01 → `rom_addr` sequence 0,4,8,…. `instr`/`instr_pc` pairs 0/0, 4/4, 8/8 on consecutive cycles starting 2 cycles after release.
- ROM acks 3 cycles after `rom_req` rises → `rom_addr` stable through each wait. Instructions are delivered in order with no gaps other than the waits, and `instr_pc` equals the address.
- `instr_ready`=0 for 10 cycles → FIFO fills to DEPTH=2, `rom_req` stays low while full, and no ack is lost. Releasing `instr_ready` → instructions resume in order: 0, 4, then 8.
- Consume at `instr_pc`=0x8 with `ps`=10, `k`=3 while 0xC is buffered → 0xC is flushed and the next delivered `instr_pc`=0x14. Repeat with `ps`=11, `k`=0x40 → next `instr_pc`=0x40.
- Redirect (`ps`=11, `k`=0x100) while a 3-wait request to 0x10 is outstanding → 0x10 data is discarded. `rom_addr`=0x100 the cycle after that ack, and the next `instr_pc`=0x100.
- `ps`=00 for 3 consumes at 0x4 → 0x4 is presented 4 times in total. Then assert `rst` low mid-request → `rom_req`=0 and `instr_valid`=0 immediately, and fetch restarts at `RESET_PC` after release.
